// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer placed after uart_rx.
// A rising edge on rxd_done captures data_in into a first-word-fall-through
// FIFO. The host drains it through a valid/ready read port. The block also
// reports occupancy and keeps a sticky overflow flag for dropped bytes.
//
// Ports:
//   clk       system clock (same clock as uart_rx)
//   rst       asynchronous active-low reset
//   rxd_done  byte-complete level from uart_rx; only its rising edge writes
//   data_in   received byte, valid while rxd_done is high
//   rd_ready  consumer takes the head byte this cycle
//   rd_valid  head byte available (registered, equals !empty)
//   rd_data   head byte, read combinationally from mem[rd_ptr]
//   count     stored bytes, 0..DEPTH (registered)
//   full      count == DEPTH (registered)
//   empty     count == 0 (registered)
//   overflow  sticky, set when a byte arrives while full with no pop
//   ovf_clr   synchronous clear of overflow; a same-cycle drop wins
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxd_done,
  input  logic [7:0]    data_in,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          done_q_r;
  logic          arm_r;
  logic          full_r;
  logic          empty_r;
  logic          valid_r;
  logic          overflow_r;

  logic          push_s;
  logic          pop_s;
  logic          wr_en_s;
  logic          drop_s;
  logic [AW:0]   count_nxt_s;

  // Decode push/pop/drop and the next occupancy from registered state.
  always_comb begin
    // arm_r blocks a push from an rxd_done level that was already high
    // when reset released (done_q resets to 0, so the edge detector alone
    // would see a false rising edge).
    push_s      = rxd_done & ~done_q_r & arm_r;
    pop_s       = rd_ready & valid_r;
    // A pop frees a slot this cycle, so a push at full is still accepted.
    wr_en_s     = push_s & (~full_r | pop_s);
    drop_s      = push_s & full_r & ~pop_s;
    count_nxt_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, flags and edge-detect state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      done_q_r   <= 1'b0;
      arm_r      <= 1'b0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      done_q_r <= rxd_done;
      arm_r    <= 1'b1;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == CNT_ZERO);
      valid_r <= (count_nxt_s != CNT_ZERO);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Byte storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  assign rd_data  = mem_r[rd_ptr_r];
  assign rd_valid = valid_r;
  assign count    = count_r;
  assign full     = full_r;
  assign empty    = empty_r;
  assign overflow = overflow_r;

endmodule
